// File: rtl/floo_axis_link_segmenter.sv
// floo_axis_link_segmenter
//   Splits AXIS payloads ({hdr, flit_data}) from the NoC bridge into fixed-width
//   link segments, LSB first (TX). It also reassembles incoming link segments
//   into full payloads for the bridge (RX). The two directions are independent,
//   and each has full valid/ready back-pressure.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   tx_payload_*             payload stream in from the bridge
//   tx_seg_*                 segment stream out to the link (last marks final segment)
//   rx_seg_*                 segment stream in from the link
//   rx_payload_*             reassembled payload stream out to the bridge
//   rx_framing_err_o         one-cycle pulse when a segment's last flag disagrees
//                            with its position in the payload
module floo_axis_link_segmenter #(
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned SegWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tx_payload_valid_i,
  output logic                    tx_payload_ready_o,
  input  logic [PayloadWidth-1:0] tx_payload_i,
  output logic                    tx_seg_valid_o,
  input  logic                    tx_seg_ready_i,
  output logic [SegWidth-1:0]     tx_seg_data_o,
  output logic                    tx_seg_last_o,
  input  logic                    rx_seg_valid_i,
  output logic                    rx_seg_ready_o,
  input  logic [SegWidth-1:0]     rx_seg_data_i,
  input  logic                    rx_seg_last_i,
  output logic                    rx_payload_valid_o,
  input  logic                    rx_payload_ready_i,
  output logic [PayloadWidth-1:0] rx_payload_o,
  output logic                    rx_framing_err_o
);

  localparam int unsigned NumSegs = (PayloadWidth + SegWidth - 1) / SegWidth;
  localparam int unsigned CntW    = (NumSegs > 1) ? $clog2(NumSegs) : 1;
  localparam int unsigned HoldW   = NumSegs * SegWidth;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSegs - 1);

  // ---------------------------------------------------------------- TX
  typedef enum logic {TxIdle, TxSend} tx_state_e;

  tx_state_e                           tx_state_q;
  logic [NumSegs-1:0][SegWidth-1:0]    tx_hold_q;
  logic [CntW-1:0]                     tx_cnt_q;
  logic                                tx_last;
  logic                                tx_last_hs;

  assign tx_last        = (tx_cnt_q == LastCnt);
  assign tx_last_hs     = (tx_state_q == TxSend) && tx_seg_ready_i && tx_last;
  // Ready stays low while reset is held. The final segment handshake also
  // frees the holding register, so the next payload can follow with no bubble.
  assign tx_payload_ready_o = rst_ni && ((tx_state_q == TxIdle) || tx_last_hs);
  assign tx_seg_valid_o = (tx_state_q == TxSend);
  assign tx_seg_data_o  = tx_hold_q[tx_cnt_q];
  assign tx_seg_last_o  = (tx_state_q == TxSend) && tx_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TxIdle;
      tx_hold_q  <= '0;
      tx_cnt_q   <= '0;
    end else begin
      case (tx_state_q)
        TxIdle: begin
          if (tx_payload_valid_i) begin
            tx_hold_q  <= HoldW'(tx_payload_i);
            tx_cnt_q   <= '0;
            tx_state_q <= TxSend;
          end
        end
        TxSend: begin
          if (tx_seg_ready_i) begin
            if (tx_last) begin
              tx_cnt_q <= '0;
              if (tx_payload_valid_i) begin
                tx_hold_q <= HoldW'(tx_payload_i);
              end else begin
                tx_state_q <= TxIdle;
              end
            end else begin
              tx_cnt_q <= tx_cnt_q + 1'b1;
            end
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  logic [NumSegs-1:0][SegWidth-1:0] rx_buf_q;
  logic [NumSegs-1:0][SegWidth-1:0] rx_asm;
  logic [HoldW-1:0]                 rx_asm_flat;
  logic [CntW-1:0]                  rx_cnt_q;
  logic [PayloadWidth-1:0]          rx_payload_q;
  logic                             rx_valid_q;
  logic                             rx_err_q;
  logic                             rx_hs;
  logic                             rx_at_last;
  logic                             rx_err;
  logic                             rx_done;

  assign rx_seg_ready_o     = rst_ni && (!rx_valid_q || rx_payload_ready_i);
  assign rx_hs              = rx_seg_valid_i && rx_seg_ready_o;
  assign rx_at_last         = (rx_cnt_q == LastCnt);
  assign rx_err             = rx_hs && (rx_seg_last_i != rx_at_last);
  assign rx_done            = rx_hs && rx_seg_last_i && rx_at_last;
  assign rx_payload_valid_o = rx_valid_q;
  assign rx_payload_o       = rx_payload_q;
  assign rx_framing_err_o   = rx_err_q;

  // The final segment bypasses the buffer so the output register can load in
  // the same cycle that the final segment is accepted.
  always_comb begin
    rx_asm           = rx_buf_q;
    rx_asm[rx_cnt_q] = rx_seg_data_i;
  end
  assign rx_asm_flat = rx_asm;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_buf_q     <= '0;
      rx_cnt_q     <= '0;
      rx_payload_q <= '0;
      rx_valid_q   <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      rx_err_q <= rx_err;
      if (rx_done) begin
        rx_payload_q <= rx_asm_flat[PayloadWidth-1:0];
        rx_valid_q   <= 1'b1;
      end else if (rx_payload_ready_i) begin
        rx_valid_q <= 1'b0;
      end
      if (rx_err || rx_done) begin
        rx_cnt_q <= '0;
      end else if (rx_hs) begin
        rx_buf_q <= rx_asm;
        rx_cnt_q <= rx_cnt_q + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_tx_seg_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (tx_seg_valid_o && !tx_seg_ready_i) |=>
      (tx_seg_valid_o && $stable(tx_seg_data_o) && $stable(tx_seg_last_o)));

  a_rx_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rx_payload_valid_o && !rx_payload_ready_i) |=>
      (rx_payload_valid_o && $stable(rx_payload_o)));
`endif

endmodule
